vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised raster timing generator, the next generation of the team's fixed 640x480@72 VGA controller. Produces h/v sync, pixel coordinates, a display-enable flag and line/frame strobes for any mode set by parameters. It adds configurable sync polarity, a run/pause enable, a frame counter and a programmable output delay so the pixel pipeline can be aligned to sync. It sits between the pixel clock domain and the pixel-generation/colour logic.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 24, horizontal front porch (clocks)
H_SYNC, 40, horizontal sync width (clocks)
H_BP, 128, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 9, vertical front porch (lines)
V_SYNC, 3, vertical sync width (lines)
V_BP, 28, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level (0 = active-low)
CW, 10, coordinate/counter width
FW, 8, frame counter width
DELAY, 0, extra output pipeline stages, 0..3

Ports:
pix_clk  input  1  pixel clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  1 = counters advance; 0 = timing frozen
hsync  output  1  horizontal sync, level per H_POL
vsync  output  1  vertical sync, level per V_POL
x_pix  output  CW  horizontal counter value
y_pix  output  CW  vertical counter value
in_display  output  1  1 when x_pix < H_ACTIVE and y_pix < V_ACTIVE
line_start  output  1  one-cycle pulse at hcount == 0
frame_start  output  1  one-cycle pulse at hcount == 0 and vcount == 0
vblank_start  output  1  one-cycle pulse at hcount == 0 and vcount == V_ACTIVE
frame_cnt  output  FW  completed frames, modulo 2^FW

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 832); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 520). Elaboration error if H_TOTAL or V_TOTAL > 2^CW, if any sync width is 0, or if DELAY > 3.
- Reset: hcount = vcount = 0, frame_cnt = 0, both phase FSMs = ACTIVE, every pipeline stage cleared: hsync = ~H_POL, vsync = ~V_POL, x_pix = y_pix = 0, in_display = 0, all strobes 0. Reset wins over en.
- Counters, en=1: hcount increments; at H_TOTAL-1 wraps to 0 and vcount increments; at vcount = V_TOTAL-1 with hcount wrap, vcount wraps to 0 and frame_cnt increments (wraps at 2^FW-1 -> 0).
- en=0: hcount, vcount, frame_cnt and both FSMs hold. The sample entering the pipeline keeps x_pix/y_pix/hsync/vsync per the held counters but forces in_display = 0 and all strobes = 0, so no strobe repeats during pause. On en reasserting, counting resumes from the held value.
- Horizontal FSM states H_ACT -> H_FP -> H_SYN -> H_BP -> H_ACT. Transitions at hcount = H_ACTIVE-1, H_ACTIVE+H_FP-1, H_ACTIVE+H_FP+H_SYNC-1, H_TOTAL-1 respectively. If H_FP or H_BP = 0 that state is skipped.
- Vertical FSM V_ACT/V_FP/V_SYN/V_BP, same scheme on vcount, advancing only on hcount wrap.
- Sync active when FSM is in SYN state: hsync = H_POL, else ~H_POL (same for vsync/V_POL).
- Output stage: decode of the current counter/FSM state is registered, then passes through DELAY further registers. Latency: outputs at cycle k reflect counter state of cycle k-1-DELAY, identically for every output including frame_cnt.
- Reset mid-frame: next cycle the counter state is (0,0); pipeline outputs are the cleared values until the first decoded sample emerges after 1+DELAY cycles, which is frame_start.

Test Plan:
- Reset, en=1, defaults, DELAY=0 -> first cycle after reset release, outputs show x=0, y=0, in_display=1, frame_start=1, line_start=1; hsync=1, vsync=1.
- Run one line -> in_display high for exactly 640 cycles; hsync low for 40 cycles starting at x_pix=664; line_start period = 832 cycles.
- Run 2 full frames -> frame_start period 832*520 = 432640 cycles; vsync low for 3*832 cycles starting at y_pix=489, x_pix=0; vblank_start at y_pix=480; frame_cnt 0->1->2.
- en low for 100 cycles at x_pix=300 -> x/y held at 300, in_display=0, no strobes; after en high x resumes 301 and line period is extended by exactly 100.
- DELAY=2, H_POL=V_POL=1, tiny mode 8/2/2/2 x 4/1/1/1, FW=2 -> all outputs shifted 2 cycles versus DELAY=0; syncs active-high; frame_cnt wraps 3->0 after 4 frames.
- Reset asserted at x=500, y=200 -> outputs cleared 1 cycle later; frame_start emerges 1+DELAY cycles after reset release.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator for any video mode set by parameters. It drives the syncs,
// the pixel coordinates, a display-enable flag, line/frame strobes and a frame counter.
// All outputs pass together through an aligned pipeline of 1+DELAY registers.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 128,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 9,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 28,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CW       = 10,
  parameter int FW       = 8,
  parameter int DELAY    = 0
) (
  input  logic          pix_clk,
  input  logic          reset,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic [CW-1:0] x_pix,
  output logic [CW-1:0] y_pix,
  output logic          in_display,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank_start,
  output logic [FW-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > (1 << CW)) begin : g_err_htotal
    $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (V_TOTAL > (1 << CW)) begin : g_err_vtotal
    $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
  end
  if (H_SYNC == 0 || V_SYNC == 0) begin : g_err_sync
    $error("vga_timing_gen: sync width must be non-zero");
  end
  if (DELAY < 0 || DELAY > 3) begin : g_err_delay
    $error("vga_timing_gen: DELAY must be 0..3");
  end

  localparam logic [CW-1:0] H_ACT_END = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] H_FP_END  = CW'(H_ACTIVE + H_FP - 1);
  localparam logic [CW-1:0] H_SYN_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT_END = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] V_FP_END  = CW'(V_ACTIVE + V_FP - 1);
  localparam logic [CW-1:0] V_SYN_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_LIM = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_LIM = CW'(V_ACTIVE);
  localparam logic          H_IDLE    = (H_POL != 0) ? 1'b0 : 1'b1;
  localparam logic          V_IDLE    = (V_POL != 0) ? 1'b0 : 1'b1;

  typedef enum logic [1:0] {PH_ACT, PH_FP, PH_SYN, PH_BP} phase_t;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          disp;
    logic          ls;
    logic          fs;
    logic          vbs;
    logic [FW-1:0] fcnt;
  } sample_t;

  localparam sample_t RST_SAMPLE = '{hs: H_IDLE, vs: V_IDLE, x: '0, y: '0, disp: 1'b0,
                                     ls: 1'b0, fs: 1'b0, vbs: 1'b0, fcnt: '0};

  // The phase after the current one. A porch of zero length is skipped.
  function automatic phase_t phase_next(input phase_t cur, input logic [CW-1:0] cnt,
                                        input logic [CW-1:0] act_end, input logic [CW-1:0] fp_end,
                                        input logic [CW-1:0] syn_end, input logic [CW-1:0] last,
                                        input logic has_fp, input logic has_bp);
    phase_t nxt;
    nxt = cur;
    case (cur)
      PH_ACT:  if (cnt == act_end) nxt = has_fp ? PH_FP : PH_SYN;
      PH_FP:   if (cnt == fp_end) nxt = PH_SYN;
      PH_SYN:  if (cnt == syn_end) nxt = has_bp ? PH_BP : PH_ACT;
      PH_BP:   if (cnt == last) nxt = PH_ACT;
      default: nxt = PH_ACT;
    endcase
    return nxt;
  endfunction

  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  logic [FW-1:0] frame_q, frame_d;
  phase_t        hph_q, hph_d;
  phase_t        vph_q, vph_d;
  logic          h_wrap;
  logic          v_last;
  sample_t       sample_d;
  sample_t       pipe_d [DELAY+1];
  sample_t       pipe_q [DELAY+1];

  assign h_wrap = (hcnt_q == H_LAST);
  assign v_last = (vcnt_q == V_LAST);

  always_comb begin
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    frame_d = frame_q;
    hph_d   = hph_q;
    vph_d   = vph_q;
    if (en) begin
      hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
      hph_d  = phase_next(hph_q, hcnt_q, H_ACT_END, H_FP_END, H_SYN_END, H_LAST,
                          (H_FP != 0), (H_BP != 0));
      if (h_wrap) begin
        vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
        vph_d  = phase_next(vph_q, vcnt_q, V_ACT_END, V_FP_END, V_SYN_END, V_LAST,
                            (V_FP != 0), (V_BP != 0));
        if (v_last) frame_d = frame_q + 1'b1;
      end
    end
  end

  // While paused the coordinates stay visible, but the enable and the strobes
  // are masked so that no line or frame event is reported twice.
  always_comb begin
    sample_d      = RST_SAMPLE;
    sample_d.hs   = (hph_q == PH_SYN) ? ~H_IDLE : H_IDLE;
    sample_d.vs   = (vph_q == PH_SYN) ? ~V_IDLE : V_IDLE;
    sample_d.x    = hcnt_q;
    sample_d.y    = vcnt_q;
    sample_d.disp = en && (hcnt_q < H_ACT_LIM) && (vcnt_q < V_ACT_LIM);
    sample_d.ls   = en && (hcnt_q == '0);
    sample_d.fs   = en && (hcnt_q == '0) && (vcnt_q == '0);
    sample_d.vbs  = en && (hcnt_q == '0) && (vcnt_q == V_ACT_LIM);
    sample_d.fcnt = frame_q;
  end

  always_comb begin
    pipe_d[0] = sample_d;
    for (int i = 1; i <= DELAY; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge pix_clk) begin
    if (reset) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      frame_q <= '0;
      hph_q   <= PH_ACT;
      vph_q   <= PH_ACT;
      for (int i = 0; i <= DELAY; i++) pipe_q[i] <= RST_SAMPLE;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      frame_q <= frame_d;
      hph_q   <= hph_d;
      vph_q   <= vph_d;
      pipe_q  <= pipe_d;
    end
  end

  assign hsync        = pipe_q[DELAY].hs;
  assign vsync        = pipe_q[DELAY].vs;
  assign x_pix        = pipe_q[DELAY].x;
  assign y_pix        = pipe_q[DELAY].y;
  assign in_display   = pipe_q[DELAY].disp;
  assign line_start   = pipe_q[DELAY].ls;
  assign frame_start  = pipe_q[DELAY].fs;
  assign vblank_start = pipe_q[DELAY].vbs;
  assign frame_cnt    = pipe_q[DELAY].fcnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. It drives a default 640x480 instance with DELAY=0
// and a tiny active-high-sync instance with DELAY=2 and FW=2.
module tb_vga_timing_gen;

  logic       pix_clk = 1'b0;
  logic       rst0 = 1'b1, en0 = 1'b0;
  logic       rst1 = 1'b1, en1 = 1'b1;
  logic       hs0, vs0, disp0, ls0, fs0, vbs0;
  logic [9:0] x0, y0;
  logic [7:0] fc0;
  logic       hs1, vs1, disp1, ls1, fs1, vbs1;
  logic [3:0] x1, y1;
  logic [1:0] fc1;
  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         line_cyc1 = 0;

  always #5 pix_clk = ~pix_clk;
  always @(posedge pix_clk) cyc <= cyc + 1;

  vga_timing_gen u_dut0 (
    .pix_clk(pix_clk), .reset(rst0), .en(en0),
    .hsync(hs0), .vsync(vs0), .x_pix(x0), .y_pix(y0), .in_display(disp0),
    .line_start(ls0), .frame_start(fs0), .vblank_start(vbs0), .frame_cnt(fc0)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1), .V_POL(1), .CW(4), .FW(2), .DELAY(2)
  ) u_dut1 (
    .pix_clk(pix_clk), .reset(rst1), .en(en1),
    .hsync(hs1), .vsync(vs1), .x_pix(x1), .y_pix(y1), .in_display(disp1),
    .line_start(ls1), .frame_start(fs1), .vblank_start(vbs1), .frame_cnt(fc1)
  );

  task automatic test_reset();
    @(negedge pix_clk); rst0 = 1'b1; en0 = 1'b1;
    @(negedge pix_clk);
    n_chk++;
    if ({hs0, vs0, x0, y0, disp0, ls0, fs0, vbs0, fc0} !== {1'b1, 1'b1, 10'd0, 10'd0, 4'd0, 8'd0})
      $display("FAIL reset_clear: got %h expected %h", {hs0, vs0, x0, y0, disp0, ls0, fs0, vbs0, fc0},
               {1'b1, 1'b1, 10'd0, 10'd0, 4'd0, 8'd0});
    else n_pass++;
    rst0 = 1'b0;
    @(negedge pix_clk);
    n_chk++;
    if ({x0, y0} !== 20'd0) $display("FAIL first_xy: got x=%0d y=%0d expected 0 0", x0, y0);
    else n_pass++;
    n_chk++;
    if ({disp0, fs0, ls0, vbs0} !== 4'b1110)
      $display("FAIL first_flags: got disp/fs/ls/vbs=%b expected 1110", {disp0, fs0, ls0, vbs0});
    else n_pass++;
    n_chk++;
    if ({hs0, vs0} !== 2'b11) $display("FAIL first_sync: got %b expected 11", {hs0, vs0});
    else n_pass++;
    $display("test_reset done at cycle %0d", cyc);
  endtask

  task automatic test_line();
    int disp_cnt = 0, hs_cnt = 0, hs_first = -1, xerr = 0, ls_cnt = 0, vs_cnt = 0;
    for (int i = 0; i < 832; i++) begin
      if (disp0) disp_cnt++;
      if (!hs0) begin
        if (hs_first < 0) hs_first = int'(x0);
        hs_cnt++;
      end
      if (!vs0) vs_cnt++;
      if (ls0) ls_cnt++;
      if (x0 !== 10'(i) || y0 !== 10'd0) xerr++;
      @(negedge pix_clk);
    end
    n_chk++;
    if (disp_cnt != 640) $display("FAIL line_disp: got %0d expected 640", disp_cnt); else n_pass++;
    n_chk++;
    if (hs_cnt != 40) $display("FAIL line_hs_width: got %0d expected 40", hs_cnt); else n_pass++;
    n_chk++;
    if (hs_first != 664) $display("FAIL line_hs_start: got %0d expected 664", hs_first); else n_pass++;
    n_chk++;
    if (xerr != 0) $display("FAIL line_xy: got %0d bad samples expected 0", xerr); else n_pass++;
    n_chk++;
    if (ls_cnt != 1 || vs_cnt != 0)
      $display("FAIL line_strobes: got ls=%0d vs_low=%0d expected 1 0", ls_cnt, vs_cnt);
    else n_pass++;
    n_chk++;
    if ({ls0, x0, y0} !== {1'b1, 10'd0, 10'd1})
      $display("FAIL line_period: got ls=%b x=%0d y=%0d expected 1 0 1", ls0, x0, y0);
    else n_pass++;
    line_cyc1 = cyc;
    $display("test_line done at cycle %0d", cyc);
  endtask

  task automatic test_pause();
    int b = 0, bad = 0;
    while (x0 !== 10'd299 && b < 1000) begin @(negedge pix_clk); b++; end
    n_chk++;
    if (x0 !== 10'd299) $display("FAIL pause_reach: got x=%0d expected 299", x0); else n_pass++;
    en0 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge pix_clk);
      if (x0 !== 10'd300 || y0 !== 10'd1 || disp0 !== 1'b0 || ls0 || fs0 || vbs0) bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL pause_hold: got %0d bad samples expected 0", bad); else n_pass++;
    en0 = 1'b1;
    @(negedge pix_clk);
    n_chk++;
    if ({x0, disp0} !== {10'd300, 1'b1})
      $display("FAIL pause_resume0: got x=%0d disp=%b expected 300 1", x0, disp0);
    else n_pass++;
    @(negedge pix_clk);
    n_chk++;
    if (x0 !== 10'd301) $display("FAIL pause_resume1: got x=%0d expected 301", x0); else n_pass++;
    b = 0;
    while (ls0 !== 1'b1 && b < 1000) begin @(negedge pix_clk); b++; end
    n_chk++;
    if (b != 531 || y0 !== 10'd2)
      $display("FAIL pause_to_line: got %0d cycles y=%0d expected 531 2", b, y0);
    else n_pass++;
    n_chk++;
    if (cyc - line_cyc1 != 932)
      $display("FAIL pause_line_period: got %0d expected 932", cyc - line_cyc1);
    else n_pass++;
    $display("test_pause done at cycle %0d", cyc);
  endtask

  task automatic test_reset_mid();
    int b = 0;
    while (x0 !== 10'd500 && b < 1000) begin @(negedge pix_clk); b++; end
    n_chk++;
    if ({x0, y0} !== {10'd500, 10'd2}) $display("FAIL mid_reach: got x=%0d y=%0d expected 500 2", x0, y0);
    else n_pass++;
    rst0 = 1'b1;
    @(negedge pix_clk);
    n_chk++;
    if ({hs0, vs0, x0, y0, disp0, ls0, fs0, vbs0, fc0} !== {1'b1, 1'b1, 10'd0, 10'd0, 4'd0, 8'd0})
      $display("FAIL mid_clear: got %h expected %h", {hs0, vs0, x0, y0, disp0, ls0, fs0, vbs0, fc0},
               {1'b1, 1'b1, 10'd0, 10'd0, 4'd0, 8'd0});
    else n_pass++;
    rst0 = 1'b0;
    @(negedge pix_clk);
    n_chk++;
    if ({fs0, ls0, disp0, x0, y0} !== {3'b111, 10'd0, 10'd0})
      $display("FAIL mid_frame_start: got fs/ls/disp=%b x=%0d y=%0d expected 111 0 0",
               {fs0, ls0, disp0}, x0, y0);
    else n_pass++;
    $display("test_reset_mid done at cycle %0d", cyc);
  endtask

  task automatic test_tiny_start();
    @(negedge pix_clk);
    n_chk++;
    if ({hs1, vs1, x1, y1, disp1, ls1, fs1, vbs1, fc1} !== 16'h0000)
      $display("FAIL tiny_clear: got %h expected 0000", {hs1, vs1, x1, y1, disp1, ls1, fs1, vbs1, fc1});
    else n_pass++;
    rst1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge pix_clk);
      n_chk++;
      if ({hs1, vs1, x1, y1, disp1, ls1, fs1, vbs1, fc1} !== 16'h0000)
        $display("FAIL tiny_latency%0d: got %h expected 0000", i,
                 {hs1, vs1, x1, y1, disp1, ls1, fs1, vbs1, fc1});
      else n_pass++;
    end
    @(negedge pix_clk);
    n_chk++;
    if ({hs1, vs1, x1, y1, disp1, ls1, fs1, vbs1, fc1} !== {2'b00, 8'h00, 4'b1110, 2'd0})
      $display("FAIL tiny_first: got %h expected %h", {hs1, vs1, x1, y1, disp1, ls1, fs1, vbs1, fc1},
               {2'b00, 8'h00, 4'b1110, 2'd0});
    else n_pass++;
    $display("test_tiny_start done at cycle %0d", cyc);
  endtask

  task automatic test_tiny_frames();
    int xyerr = 0, hs_cnt = 0, vs_cnt = 0, disp_cnt = 0, fs_cnt = 0, vbs_cnt = 0, vbs_err = 0;
    int hs_first = -1, vs_first = -1;
    logic [7:0] fc_pack = 8'h00;
    for (int s = 0; s < 392; s++) begin
      if (x1 !== 4'(s % 14) || y1 !== 4'((s / 14) % 7)) xyerr++;
      if (hs1) begin
        if (hs_first < 0) hs_first = int'(x1);
        hs_cnt++;
      end
      if (vs1) begin
        if (vs_first < 0) vs_first = int'({y1, x1});
        vs_cnt++;
      end
      if (disp1) disp_cnt++;
      if (vbs1) begin
        vbs_cnt++;
        if (y1 !== 4'd4 || x1 !== 4'd0) vbs_err++;
      end
      if (fs1) begin
        fs_cnt++;
        fc_pack = {fc_pack[5:0], fc1};
      end
      @(negedge pix_clk);
    end
    n_chk++;
    if (xyerr != 0) $display("FAIL tiny_xy: got %0d bad samples expected 0", xyerr); else n_pass++;
    n_chk++;
    if (hs_cnt != 56 || hs_first != 10)
      $display("FAIL tiny_hsync: got count=%0d first_x=%0d expected 56 10", hs_cnt, hs_first);
    else n_pass++;
    n_chk++;
    if (vs_cnt != 56 || vs_first != 8'h50)
      $display("FAIL tiny_vsync: got count=%0d first_yx=%0h expected 56 50", vs_cnt, vs_first);
    else n_pass++;
    n_chk++;
    if (disp_cnt != 128) $display("FAIL tiny_disp: got %0d expected 128", disp_cnt); else n_pass++;
    n_chk++;
    if (vbs_cnt != 4 || vbs_err != 0)
      $display("FAIL tiny_vblank: got count=%0d bad=%0d expected 4 0", vbs_cnt, vbs_err);
    else n_pass++;
    n_chk++;
    if (fs_cnt != 4 || fc_pack !== 8'h1B)
      $display("FAIL tiny_frame_cnt: got fs=%0d seq=%h expected 4 1b", fs_cnt, fc_pack);
    else n_pass++;
    n_chk++;
    if ({fs1, fc1} !== 3'b100) $display("FAIL tiny_fc_wrap: got fs=%b fc=%0d expected 1 0", fs1, fc1);
    else n_pass++;
    $display("test_tiny_frames done at cycle %0d", cyc);
  endtask

  task automatic test_tiny_reset_mid();
    int b = 0;
    while (!(x1 === 4'd5 && y1 === 4'd2 && fc1 === 2'd1) && b < 300) begin @(negedge pix_clk); b++; end
    n_chk++;
    if ({x1, y1, fc1} !== {4'd5, 4'd2, 2'd1})
      $display("FAIL tiny_mid_reach: got x=%0d y=%0d fc=%0d expected 5 2 1", x1, y1, fc1);
    else n_pass++;
    rst1 = 1'b1;
    @(negedge pix_clk);
    n_chk++;
    if ({hs1, vs1, x1, y1, disp1, ls1, fs1, vbs1, fc1} !== 16'h0000)
      $display("FAIL tiny_mid_clear: got %h expected 0000", {hs1, vs1, x1, y1, disp1, ls1, fs1, vbs1, fc1});
    else n_pass++;
    rst1 = 1'b0;
    @(negedge pix_clk);
    @(negedge pix_clk);
    n_chk++;
    if ({hs1, vs1, x1, y1, disp1, ls1, fs1, vbs1, fc1} !== 16'h0000)
      $display("FAIL tiny_mid_latency: got %h expected 0000", {hs1, vs1, x1, y1, disp1, ls1, fs1, vbs1, fc1});
    else n_pass++;
    @(negedge pix_clk);
    n_chk++;
    if ({fs1, x1, y1, fc1} !== {1'b1, 4'd0, 4'd0, 2'd0})
      $display("FAIL tiny_mid_frame_start: got fs=%b x=%0d y=%0d fc=%0d expected 1 0 0 0", fs1, x1, y1, fc1);
    else n_pass++;
    $display("test_tiny_reset_mid done at cycle %0d", cyc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_line();
    test_pause();
    test_reset_mid();
    test_tiny_start();
    test_tiny_frames();
    test_tiny_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
